pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
Sequencer between the decode-stage PC target adder and fetch. It accepts taken branch/jump target requests from decode and higher-priority redirects from execute, and waits for the JALR source operand when it is not yet forwarded. It checks target alignment, holds a single redirect until fetch accepts it, and generates the decode stall and fetch/decode flush.

Parameters:
CNT_W, 32, width of the accepted-redirect counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
dec_valid  in  1  decode holds a resolved branch/jump this cycle
dec_taken  in  1  branch taken (JAL/JALR always drive 1)
dec_is_jalr  in  1  request is JALR; target depends on rs1
dec_target  in  64  pc+offset target for BEQ/JAL
jalr_target  in  64  rs1+imm target from forwarded reg data, low bit not yet cleared
jalr_src_ready  in  1  forwarded rs1 valid this cycle
exe_valid  in  1  execute-stage redirect (older instruction, highest priority)
exe_target  in  64  execute redirect target
fetch_ready  in  1  fetch accepts redirect this cycle
redirect_valid  out  1  redirect pending toward fetch (registered)
redirect_pc  out  64  redirect target (registered)
flush_fd  out  1  kill fetch/decode wrong-path instrs; = redirect_valid & fetch_ready
stall_dec  out  1  hold decode (combinational)
misalign  out  1  one-cycle pulse: decode target had bit1 set (registered)
misalign_pc  out  64  offending target, valid with misalign (registered)
redirect_count  out  CNT_W  number of accepted redirects (registered)

Behaviour:
- Reset (reset=0, async): state=IDLE; redirect_valid=0, redirect_pc=0, misalign=0, misalign_pc=0, redirect_count=0; any pending/waiting request is dropped. stall_dec=0 while reset is held.
- Decode target: T = dec_is_jalr ? (jalr_target & ~64'h1) : dec_target. Misaligned if T[1]=1. Misaligned targets produce no redirect: misalign=1 and misalign_pc=T next cycle.
- States: IDLE, WAIT_SRC, HOLD.
- IDLE:
  - exe_valid: latch exe_target; go to HOLD. Decode request in the same cycle is ignored, since it is wrong-path.
  - Else if dec_valid & dec_taken & dec_is_jalr & !jalr_src_ready: go to WAIT_SRC; stall_dec=1 this cycle.
  - Else if dec_valid & dec_taken: if T is aligned, latch T and go to HOLD; if misaligned, pulse misalign and stay in IDLE.
  - dec_valid & !dec_taken: no action.
- WAIT_SRC:
  - stall_dec=1. Decode holds its inputs stable.
  - exe_valid: latch exe_target and go to HOLD; the JALR is abandoned.
  - Else if jalr_src_ready: evaluate T as in IDLE; go to HOLD, or to IDLE with a misalign pulse.
- HOLD:
  - redirect_valid=1, stall_dec=1.
  - Handshake = fetch_ready: flush_fd=1 and redirect_count+=1 (wraps), with the following cases:
    - Handshake and !exe_valid: go to IDLE; redirect_valid=0 next cycle.
    - exe_valid and !fetch_ready: redirect_pc is overwritten with exe_target; stay in HOLD; count unchanged.
    - Handshake and exe_valid in the same cycle: the old target is accepted (counted), exe_target is latched, and redirect_valid stays 1.
- Latency: from an accepted decode or execute request to redirect_valid is 1 cycle. redirect_pc never changes in HOLD except on an exe override.
- Outputs are only ever driven to known values; no X on redirect_pc while redirect_valid=0 (it keeps its last value).

Test Plan:
- BEQ taken, dec_target=0x8000_0010, fetch_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x8000_0010, flush_fd=1; following cycle redirect_valid=0, redirect_count=1.
- JALR with jalr_src_ready=0 for 2 cycles, then 1 with jalr_target=0x8000_0101 -> stall_dec=1 for the 2 wait cycles; then redirect_pc=0x8000_0100.
- JAL target 0x8000_0006 -> misalign=1 for one cycle, misalign_pc=0x8000_0006, no redirect_valid, count unchanged.
- HOLD with fetch_ready=0 for 3 cycles, exe_valid with exe_target=0x8000_2000 in cycle 2 -> redirect_pc switches to 0x8000_2000; one handshake, count+1.
- exe_valid and taken dec_valid in the same IDLE cycle -> only exe_target is issued; the decode request is dropped.
- reset=0 asserted mid-HOLD (between clock edges) -> redirect_valid, redirect_count and misalign go to 0 immediately; after release, IDLE and stall_dec=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencer between the decode-stage target adder and fetch.
// Arbitrates execute/decode redirects, waits for JALR rs1, and holds one redirect until fetch takes it.
module pc_redirect_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic             dec_taken,
    input  logic             dec_is_jalr,
    input  logic [63:0]      dec_target,
    input  logic [63:0]      jalr_target,
    input  logic             jalr_src_ready,
    input  logic             exe_valid,
    input  logic [63:0]      exe_target,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic             flush_fd,
    output logic             stall_dec,
    output logic             misalign,
    output logic [63:0]      misalign_pc,
    output logic [CNT_W-1:0] redirect_count,
    output logic [1:0]       state_dbg
);

    // Handshake: redirect_valid is held with a stable redirect_pc (except on an
    // execute override) and a transfer happens on any cycle with redirect_valid & fetch_ready.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SRC = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [63:0]        dec_t;
    logic [63:0]        pc_n;
    logic [63:0]        mis_pc_n;
    logic               mis_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               stall_n;

    // JALR clears the low bit of rs1+imm; bit 1 then decides alignment.
    assign dec_t = dec_is_jalr ? (jalr_target & ~64'h1) : dec_target;

    always_comb begin
        state_n  = state;
        pc_n     = redirect_pc;
        mis_n    = 1'b0;
        mis_pc_n = misalign_pc;
        cnt_n    = redirect_count;
        stall_n  = 1'b0;
        case (state)
            IDLE: begin
                if (exe_valid) begin
                    state_n = HOLD;
                    pc_n    = exe_target;
                end else if (dec_valid && dec_taken) begin
                    if (dec_is_jalr && !jalr_src_ready) begin
                        state_n = WAIT_SRC;
                        stall_n = 1'b1;
                    end else if (dec_t[1]) begin
                        mis_n    = 1'b1;
                        mis_pc_n = dec_t;
                    end else begin
                        state_n = HOLD;
                        pc_n    = dec_t;
                    end
                end
            end
            WAIT_SRC: begin
                stall_n = 1'b1;
                if (exe_valid) begin
                    state_n = HOLD;
                    pc_n    = exe_target;
                end else if (jalr_src_ready) begin
                    if (dec_t[1]) begin
                        state_n  = IDLE;
                        mis_n    = 1'b1;
                        mis_pc_n = dec_t;
                    end else begin
                        state_n = HOLD;
                        pc_n    = dec_t;
                    end
                end
            end
            HOLD: begin
                stall_n = 1'b1;
                if (fetch_ready) begin
                    cnt_n = redirect_count + CNT_W'(1);
                end
                // An execute override replaces the target; the old one is still counted if fetch took it.
                if (exe_valid) begin
                    pc_n = exe_target;
                end else if (fetch_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            redirect_pc    <= 64'h0;
            misalign       <= 1'b0;
            misalign_pc    <= 64'h0;
            redirect_count <= '0;
        end else begin
            state          <= state_n;
            redirect_pc    <= pc_n;
            misalign       <= mis_n;
            misalign_pc    <= mis_pc_n;
            redirect_count <= cnt_n;
        end
    end

    assign redirect_valid = (state == HOLD);
    assign flush_fd       = redirect_valid & fetch_ready;
    assign stall_dec      = stall_n & reset;
    assign state_dbg      = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed test-plan cases then random traffic,
// checked against a behavioural model and a queue of expected accepted redirects.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic        dec_taken;
    logic        dec_is_jalr;
    logic [63:0] dec_target;
    logic [63:0] jalr_target;
    logic        jalr_src_ready;
    logic        exe_valid;
    logic [63:0] exe_target;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush_fd;
    logic        stall_dec;
    logic        misalign;
    logic [63:0] misalign_pc;
    logic [31:0] redirect_count;
    logic [1:0]  state_dbg;

    pc_redirect_ctrl #(.CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_taken      (dec_taken),
        .dec_is_jalr    (dec_is_jalr),
        .dec_target     (dec_target),
        .jalr_target    (jalr_target),
        .jalr_src_ready (jalr_src_ready),
        .exe_valid      (exe_valid),
        .exe_target     (exe_target),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_fd       (flush_fd),
        .stall_dec      (stall_dec),
        .misalign       (misalign),
        .misalign_pc    (misalign_pc),
        .redirect_count (redirect_count),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mis_q[$];

    // Behavioural model: a redirect is either pending toward fetch or not,
    // a JALR is either waiting for rs1 or not.
    logic        m_pend;
    logic        m_wait;
    logic        m_mis;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0;
        m_wait = 1'b0;
        m_mis  = 1'b0;
        m_pc   = 64'h0;
        m_cnt  = 32'h0;
        exp_q.delete();
        mis_q.delete();
    endtask

    task automatic start_redirect(input logic [63:0] t);
        m_pend = 1'b1;
        m_pc   = t;
        exp_q.push_back(t);
    endtask

    task automatic model_step();
        logic [63:0] t;
        if (!reset) begin
            model_reset();
            return;
        end
        m_mis = 1'b0;
        t = dec_is_jalr ? {jalr_target[63:1], 1'b0} : dec_target;
        if (m_pend) begin
            if (fetch_ready) begin
                m_cnt = m_cnt + 32'd1;
                if (exe_valid) start_redirect(exe_target);
                else m_pend = 1'b0;
            end else if (exe_valid) begin
                if (exp_q.size() > 0) void'(exp_q.pop_back());
                start_redirect(exe_target);
            end
        end else if (exe_valid) begin
            m_wait = 1'b0;
            start_redirect(exe_target);
        end else if (m_wait || (dec_valid && dec_taken)) begin
            if (dec_is_jalr && !jalr_src_ready) begin
                m_wait = 1'b1;
            end else begin
                m_wait = 1'b0;
                if (t[1]) begin
                    m_mis = 1'b1;
                    mis_q.push_back(t);
                end else begin
                    start_redirect(t);
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = reset && (m_pend || m_wait ||
                    (!exe_valid && dec_valid && dec_taken && dec_is_jalr && !jalr_src_ready));
        check("redirect_valid", {63'h0, redirect_valid}, {63'h0, m_pend});
        if (m_pend) check("redirect_pc", redirect_pc, m_pc);
        check("flush_fd", {63'h0, flush_fd}, {63'h0, m_pend && fetch_ready});
        if (flush_fd) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL accepted_pc actual=0x%0h expected=none (queue empty) at %0t", redirect_pc, $time);
            end else begin
                check("accepted_pc", redirect_pc, exp_q.pop_front());
            end
        end
        check("redirect_count", {32'h0, redirect_count}, {32'h0, m_cnt});
        check("misalign", {63'h0, misalign}, {63'h0, m_mis});
        if (misalign) begin
            if (mis_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL misalign_pc actual=0x%0h expected=none (queue empty) at %0t", misalign_pc, $time);
            end else begin
                check("misalign_pc", misalign_pc, mis_q.pop_front());
            end
        end
        check("stall_dec", {63'h0, stall_dec}, {63'h0, exp_stall});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_dec(input logic v, input logic tk, input logic j,
                             input logic [63:0] dt, input logic [63:0] jt, input logic rdy);
        dec_valid      = v;
        dec_taken      = tk;
        dec_is_jalr    = j;
        dec_target     = dt;
        jalr_target    = jt;
        jalr_src_ready = rdy;
    endtask

    task automatic idle_dec();
        drive_dec(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {$urandom, $urandom};
        t[1] = ($urandom_range(0, 3) == 0);
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        reset       = 1'b0;
        exe_valid   = 1'b0;
        exe_target  = 64'h0;
        fetch_ready = 1'b0;
        idle_dec();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // BEQ taken, fetch ready immediately
        fetch_ready = 1'b1;
        drive_dec(1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'h0, 1'b0);
        tick();
        idle_dec();
        tick();
        tick();

        // JALR waits two cycles for rs1, then low bit is cleared
        drive_dec(1'b1, 1'b1, 1'b1, 64'h0, 64'h8000_0101, 1'b0);
        tick();
        tick();
        jalr_src_ready = 1'b1;
        tick();
        idle_dec();
        tick();
        tick();

        // JAL to a target with bit 1 set
        drive_dec(1'b1, 1'b1, 1'b0, 64'h8000_0006, 64'h0, 1'b0);
        tick();
        idle_dec();
        tick();
        tick();

        // HOLD with fetch stalled, execute overrides in the second hold cycle
        fetch_ready = 1'b0;
        drive_dec(1'b1, 1'b1, 1'b0, 64'h8000_1000, 64'h0, 1'b0);
        tick();
        idle_dec();
        tick();
        exe_valid  = 1'b1;
        exe_target = 64'h8000_2000;
        tick();
        exe_valid = 1'b0;
        tick();
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        tick();

        // execute and taken decode in the same IDLE cycle
        fetch_ready = 1'b1;
        exe_valid   = 1'b1;
        exe_target  = 64'h8000_3000;
        drive_dec(1'b1, 1'b1, 1'b0, 64'h8000_4000, 64'h0, 1'b0);
        tick();
        exe_valid = 1'b0;
        idle_dec();
        tick();
        tick();

        // asynchronous reset in the middle of a HOLD cycle
        fetch_ready = 1'b0;
        drive_dec(1'b1, 1'b1, 1'b0, 64'h8000_5000, 64'h0, 1'b0);
        tick();
        idle_dec();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
        check("rst_redirect_count", {32'h0, redirect_count}, 64'h0);
        check("rst_misalign", {63'h0, misalign}, 64'h0);
        check("rst_stall_dec", {63'h0, stall_dec}, 64'h0);
        check("rst_state", {62'h0, state_dbg}, 64'h0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_stall_dec", {63'h0, stall_dec}, 64'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!(m_pend || m_wait)) begin
                drive_dec($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          rand_target(), rand_target(), $urandom_range(0, 1));
            end else begin
                jalr_target    = rand_target();
                jalr_src_ready = ($urandom_range(0, 2) == 0);
            end
            exe_valid   = ($urandom_range(0, 7) == 0);
            exe_target  = {$urandom, $urandom};
            fetch_ready = $urandom_range(0, 1);
            tick();
        end

        exe_valid   = 1'b0;
        fetch_ready = 1'b1;
        idle_dec();
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
